xgriscv_dmem_hs: RTL and testbench

Parametrised data memory for the xgriscv core with a valid/ready request channel, configurable read latency, RISC-V load/store width decoding, load sign extension and misalignment detection. It replaces the single-cycle combinational-read data memory: the memory stage issues one request, stalls on `req_ready`, and consumes one response.

---
 rtl/xgriscv_mem_pkg.sv | 41 ++++
 rtl/dmem_lsu_align.sv | 55 +++++
 rtl/xgriscv_dmem_hs.sv | 167 ++++++++++++++++
 tb/tb_xgriscv_dmem_hs.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/xgriscv_mem_pkg.sv
// Shared definitions for the xgriscv data memory: funct3 encodings, handshake FSM states,
// and request legality helpers.
package xgriscv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Access size lives in funct3[1:0] for both signed and unsigned loads.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (funct3[1:0] == 2'b01 && addr_lo[0])
            bad = 1'b1;
        if (funct3[1:0] == 2'b10 && addr_lo != 2'b00)
            bad = 1'b1;
        return bad;
    endfunction

    function automatic logic illegal_funct3(input logic we, input logic [2:0] funct3);
        logic bad;
        if (we)
            bad = !(funct3 == F3_SB || funct3 == F3_SH || funct3 == F3_SW);
        else
            bad = !(funct3 == F3_LB || funct3 == F3_LH || funct3 == F3_LW ||
                    funct3 == F3_LBU || funct3 == F3_LHU);
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Combinational RV32 load/store lane handling: store byte enables and data replication,
// load byte/half extraction with sign or zero extension.
module dmem_lsu_align
    import xgriscv_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      st_size_i,
    input  logic [1:0]      st_addr_lo_i,
    input  logic [XLEN-1:0] st_wdata_i,
    output logic [3:0]      st_be_o,
    output logic [XLEN-1:0] st_wdata_o,
    input  logic [2:0]      ld_funct3_i,
    input  logic [1:0]      ld_addr_lo_i,
    input  logic [XLEN-1:0] ld_word_i,
    output logic [XLEN-1:0] ld_data_o
);

    logic [XLEN-1:0] ld_shift;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    always_comb begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_wdata_i;
        case (st_size_i)
            2'b00: begin
                st_be_o    = 4'b0001 << st_addr_lo_i;
                st_wdata_o = {4{st_wdata_i[7:0]}};
            end
            2'b01: begin
                st_be_o    = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_o = {2{st_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Bring the addressed byte down to lane 0 before extension.
    assign ld_shift = ld_word_i >> {ld_addr_lo_i, 3'b000};
    assign ld_byte  = ld_shift[7:0];
    assign ld_half  = ld_addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

    always_comb begin
        ld_data_o = ld_word_i;
        case (ld_funct3_i)
            F3_LB:   ld_data_o = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            F3_LH:   ld_data_o = {{(XLEN-16){ld_half[15]}}, ld_half};
            F3_LBU:  ld_data_o = {{(XLEN-8){1'b0}}, ld_byte};
            F3_LHU:  ld_data_o = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/xgriscv_dmem_hs.sv
// xgriscv data memory with valid/ready request/response handshake and configurable
// read latency; stores commit on the accept edge, loads sample the word entering RESP.
module xgriscv_dmem_hs
    import xgriscv_mem_pkg::*;
#(
    parameter int    XLEN      = 32,
    parameter int    DEPTH     = 1024,
    parameter int    LATENCY   = 1,
    parameter string INIT_FILE = ""
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

    logic [XLEN-1:0] mem [DEPTH];

    state_e          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      lo_q, lo_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            rerr_q, rerr_d;

    logic            accept;
    logic            req_err;
    logic [AW-1:0]   req_idx;
    logic            enter_resp;
    logic            cur_we;
    logic [2:0]      cur_f3;
    logic [1:0]      cur_lo;
    logic [AW-1:0]   cur_idx;
    logic            cur_err;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata;
    logic [XLEN-1:0] ld_data;
    logic            unused_addr;

    assign req_ready   = (state_q == ST_IDLE) && rstn;
    assign accept      = req_valid && req_ready;
    assign req_idx     = req_addr[AW+1:2];
    assign req_err     = misaligned(req_funct3, req_addr[1:0]) || illegal_funct3(req_we, req_funct3);
    assign unused_addr = ^req_addr[XLEN-1:AW+2];

    // With LATENCY=1 the response is formed on the accept edge, so read the live request.
    assign cur_we  = (state_q == ST_IDLE) ? req_we          : we_q;
    assign cur_f3  = (state_q == ST_IDLE) ? req_funct3      : f3_q;
    assign cur_lo  = (state_q == ST_IDLE) ? req_addr[1:0]   : lo_q;
    assign cur_idx = (state_q == ST_IDLE) ? req_idx         : idx_q;
    assign cur_err = (state_q == ST_IDLE) ? req_err         : err_q;

    dmem_lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .st_size_i    (req_funct3[1:0]),
        .st_addr_lo_i (req_addr[1:0]),
        .st_wdata_i   (req_wdata),
        .st_be_o      (st_be),
        .st_wdata_o   (st_wdata),
        .ld_funct3_i  (cur_f3),
        .ld_addr_lo_i (cur_lo),
        .ld_word_i    (mem[cur_idx]),
        .ld_data_o    (ld_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        f3_d       = f3_q;
        lo_d       = lo_q;
        idx_d      = idx_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        rerr_d     = rerr_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d  = req_we;
                    f3_d  = req_funct3;
                    lo_d  = req_addr[1:0];
                    idx_d = req_idx;
                    err_d = req_err;
                    cnt_d = CNT_INIT;
                    if (LATENCY > 1) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q <= 2'd1) begin
                    cnt_d      = 2'd0;
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (enter_resp) begin
            rerr_d  = cur_err;
            rdata_d = (cur_err || cur_we) ? '0 : ld_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            lo_q    <= 2'b00;
            idx_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            lo_q    <= lo_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

    // Storage is not reset; an accepted store stays committed across a later reset.
    always_ff @(posedge clk) begin
        if (accept && req_we && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i])
                    mem[req_idx][8*i +: 8] <= st_wdata[8*i +: 8];
            end
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rerr_q;

endmodule

// File: tb/tb_xgriscv_dmem_hs.sv
// Directed bench for xgriscv_dmem_hs: a LATENCY=1 instance driven from a vector table,
// and a LATENCY=3 instance for response hold and mid-operation reset sequences.
module tb_xgriscv_dmem_hs;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rv [2];
    logic        rr [2];
    logic        we [2];
    logic [2:0]  f3 [2];
    logic [31:0] addr [2];
    logic [31:0] wd [2];
    logic        sv [2];
    logic        sr [2];
    logic [31:0] rd [2];
    logic        er [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xgriscv_dmem_hs #(.XLEN(32), .DEPTH(1024), .LATENCY(1), .INIT_FILE("")) dut_a (
        .clk(clk), .rstn(rstn),
        .req_valid(rv[0]), .req_ready(rr[0]), .req_we(we[0]), .req_funct3(f3[0]),
        .req_addr(addr[0]), .req_wdata(wd[0]),
        .rsp_valid(sv[0]), .rsp_ready(sr[0]), .rsp_rdata(rd[0]), .rsp_err(er[0])
    );

    xgriscv_dmem_hs #(.XLEN(32), .DEPTH(256), .LATENCY(3), .INIT_FILE("")) dut_b (
        .clk(clk), .rstn(rstn),
        .req_valid(rv[1]), .req_ready(rr[1]), .req_we(we[1]), .req_funct3(f3[1]),
        .req_addr(addr[1]), .req_wdata(wd[1]),
        .rsp_valid(sv[1]), .rsp_ready(sr[1]), .rsp_rdata(rd[1]), .rsp_err(er[1])
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
        logic        exp_err;
    } vec_t;

    vec_t vt [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic txn(input int d, input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] data, input int hold,
                       output logic [31:0] rdata, output logic err, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!rr[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_before", {31'd0, rr[d]}, 32'd1);
        rv[d] = 1'b1; we[d] = w; f3[d] = f; addr[d] = a; wd[d] = data;
        @(posedge clk);
        #1;
        rv[d] = 1'b0; we[d] = 1'b0; wd[d] = 32'hDEAD_BEEF;
        lat = 1;
        while (!sv[d] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = rd[d];
        err   = er[d];
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("hold_valid", {31'd0, sv[d]}, 32'd1);
            chk("hold_rdata", rd[d], rdata);
            chk("hold_ready", {31'd0, rr[d]}, 32'd0);
        end
        sr[d] = 1'b1;
        @(posedge clk);
        #1;
        sr[d] = 1'b0;
        chk("post_valid", {31'd0, sv[d]}, 32'd0);
        chk("post_ready", {31'd0, rr[d]}, 32'd1);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        int          lat;

        vt[0]  = '{1'b1, 3'b010, 32'h100,  32'h1234_5678, 32'h0000_0000, 1'b0};
        vt[1]  = '{1'b0, 3'b010, 32'h100,  32'h0,         32'h1234_5678, 1'b0};
        vt[2]  = '{1'b1, 3'b000, 32'h101,  32'h0000_00AB, 32'h0000_0000, 1'b0};
        vt[3]  = '{1'b0, 3'b000, 32'h101,  32'h0,         32'hFFFF_FFAB, 1'b0};
        vt[4]  = '{1'b0, 3'b100, 32'h101,  32'h0,         32'h0000_00AB, 1'b0};
        vt[5]  = '{1'b0, 3'b010, 32'h100,  32'h0,         32'h1234_AB78, 1'b0};
        vt[6]  = '{1'b1, 3'b001, 32'h102,  32'h0000_8001, 32'h0000_0000, 1'b0};
        vt[7]  = '{1'b0, 3'b001, 32'h102,  32'h0,         32'hFFFF_8001, 1'b0};
        vt[8]  = '{1'b0, 3'b101, 32'h102,  32'h0,         32'h0000_8001, 1'b0};
        vt[9]  = '{1'b0, 3'b010, 32'h100,  32'h0,         32'h8001_AB78, 1'b0};
        vt[10] = '{1'b0, 3'b010, 32'h102,  32'h0,         32'h0000_0000, 1'b1};
        vt[11] = '{1'b1, 3'b001, 32'h101,  32'h0000_FFFF, 32'h0000_0000, 1'b1};
        vt[12] = '{1'b0, 3'b010, 32'h100,  32'h0,         32'h8001_AB78, 1'b0};
        vt[13] = '{1'b1, 3'b100, 32'h100,  32'h0000_0000, 32'h0000_0000, 1'b1};
        vt[14] = '{1'b0, 3'b011, 32'h100,  32'h0,         32'h0000_0000, 1'b1};
        vt[15] = '{1'b1, 3'b010, 32'h101,  32'h0000_0000, 32'h0000_0000, 1'b1};
        vt[16] = '{1'b0, 3'b010, 32'h100,  32'h0,         32'h8001_AB78, 1'b0};
        vt[17] = '{1'b1, 3'b000, 32'h103,  32'hFFFF_FF5A, 32'h0000_0000, 1'b0};
        vt[18] = '{1'b0, 3'b000, 32'h103,  32'h0,         32'h0000_005A, 1'b0};
        vt[19] = '{1'b0, 3'b001, 32'h100,  32'h0,         32'hFFFF_AB78, 1'b0};
        vt[20] = '{1'b0, 3'b000, 32'h100,  32'h0,         32'h0000_0078, 1'b0};
        vt[21] = '{1'b0, 3'b010, 32'h1100, 32'h0,         32'h5A01_AB78, 1'b0};

        for (int d = 0; d < 2; d++) begin
            rv[d] = 1'b0; we[d] = 1'b0; f3[d] = 3'b000; addr[d] = '0; wd[d] = '0; sr[d] = 1'b0;
        end

        // Reset state while rstn is held low.
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_req_ready", {31'd0, rr[d]}, 32'd0);
            chk("rst_rsp_valid", {31'd0, sv[d]}, 32'd0);
            chk("rst_rsp_rdata", rd[d], 32'd0);
            chk("rst_rsp_err",   {31'd0, er[d]}, 32'd0);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 22; i++) begin
            txn(0, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd, 0, r, e, lat);
            chk($sformatf("v%0d_lat", i),   lat, 32'd1);
            chk($sformatf("v%0d_rdata", i), r, vt[i].exp);
            chk($sformatf("v%0d_err", i),   {31'd0, e}, {31'd0, vt[i].exp_err});
        end

        // LATENCY=3: store, then a load whose response is back-pressured for 5 cycles.
        txn(1, 1'b1, 3'b010, 32'h20, 32'hCAFE_F00D, 0, r, e, lat);
        chk("b_sw_lat", lat, 32'd3);
        chk("b_sw_err", {31'd0, e}, 32'd0);
        txn(1, 1'b0, 3'b010, 32'h20, 32'h0, 5, r, e, lat);
        chk("b_lw_lat",   lat, 32'd3);
        chk("b_lw_rdata", r, 32'hCAFE_F00D);
        chk("b_lw_err",   {31'd0, e}, 32'd0);
        txn(1, 1'b0, 3'b001, 32'h23, 32'h0, 0, r, e, lat);
        chk("b_lh_mis_lat",   lat, 32'd3);
        chk("b_lh_mis_rdata", r, 32'd0);
        chk("b_lh_mis_err",   {31'd0, e}, 32'd1);

        // Reset during WAIT of a load: response discarded, memory intact.
        @(negedge clk);
        rv[1] = 1'b1; we[1] = 1'b0; f3[1] = 3'b010; addr[1] = 32'h20;
        @(posedge clk);
        #1;
        rv[1] = 1'b0;
        chk("mid_in_wait_valid", {31'd0, sv[1]}, 32'd0);
        chk("mid_in_wait_ready", {31'd0, rr[1]}, 32'd0);
        rstn = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, rr[1]}, 32'd0);
        chk("mid_rst_valid", {31'd0, sv[1]}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("mid_rel_ready", {31'd0, rr[1]}, 32'd1);
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("mid_rel_valid", {31'd0, sv[1]}, 32'd0);
        end
        txn(1, 1'b0, 3'b010, 32'h20, 32'h0, 0, r, e, lat);
        chk("mid_after_rdata", r, 32'hCAFE_F00D);
        chk("mid_after_lat",   lat, 32'd3);
        txn(0, 1'b0, 3'b010, 32'h100, 32'h0, 0, r, e, lat);
        chk("a_after_rst_rdata", r, 32'h5A01_AB78);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
